// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARB       = 3'd1,
    ST_LOAD      = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_GAP       = 3'd5
  } state_t;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int TX_START_PULSE = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set req bit at or above ptr, wrapping; one-hot result.
// Purely combinational, zero latency; no flow control of its own.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt
);

  int   idx;
  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx[PTR_W-1:0]]) begin
        gnt[idx[PTR_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX path between NUM_REQ byte streams, round-robin per message.
// req_ready same cycle as an accepted req_valid, tx_start one cycle later; owner holds grant until its last byte.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int NUM_REQ     = 2,
  parameter int ACK_TIMEOUT = 64,
  parameter int GAP_CYCLES  = 0
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_start,
  input  logic                          tsr_busy,
  output logic                          timeout_err,
  input  logic                          err_clr
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  state_t              state;
  logic [PTR_W-1:0]    ptr;
  logic [CNT_W-1:0]    cnt;
  logic [7:0]          gap_cnt;
  logic                last_q;

  logic [NUM_REQ-1:0]    pick;
  logic [NUM_REQ-1:0]    sel_oh;
  logic [NUM_REQ-1:0]    accept_oh;
  logic [DATA_WIDTH-1:0] sel_dat;
  logic                  sel_last;
  logic [PTR_W-1:0]      owner_idx;
  logic [PTR_W-1:0]      next_ptr;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req (req_valid),
    .ptr (ptr),
    .gnt (pick)
  );

  // An existing owner locks out everyone else until its message ends.
  assign sel_oh    = (|grant) ? grant : pick;
  assign accept_oh = (state == ST_ARB) ? (sel_oh & req_valid) : '0;
  assign req_ready = accept_oh;
  assign sel_last  = |(sel_oh & req_last);

  always_comb begin
    owner_idx = '0;
    sel_dat   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i])  owner_idx = PTR_W'(i);
      if (sel_oh[i]) sel_dat   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign next_ptr = (owner_idx == PTR_W'(NUM_REQ - 1)) ? '0 : owner_idx + 1'b1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      cnt         <= '0;
      gap_cnt     <= '0;
      last_q      <= 1'b0;
      grant       <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // A timeout below overrides this clear in the same cycle.
      if (err_clr) timeout_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!tsr_busy && (|req_valid)) state <= ST_ARB;
        end

        ST_ARB: begin
          if (|accept_oh) begin
            grant    <= accept_oh;
            tx_data  <= sel_dat;
            last_q   <= sel_last;
            tx_start <= 1'b1;
            cnt      <= '0;
            state    <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          if (cnt == CNT_W'(TX_START_PULSE - 1)) begin
            tx_start <= 1'b0;
            cnt      <= '0;
            state    <= ST_WAIT_ACK;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_WAIT_ACK: begin
          if (tsr_busy) begin
            state <= ST_WAIT_DONE;
          end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            grant       <= '0;
            ptr         <= next_ptr;
            state       <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_WAIT_DONE: begin
          if (!tsr_busy) begin
            if (GAP_CYCLES > 0) begin
              gap_cnt <= '0;
              state   <= ST_GAP;
            end else if (last_q) begin
              grant <= '0;
              ptr   <= next_ptr;
              state <= ST_IDLE;
            end else begin
              state <= ST_ARB;
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt == 8'(GAP_CYCLES - 1)) begin
            if (last_q) begin
              grant <= '0;
              ptr   <= next_ptr;
              state <= ST_IDLE;
            end else begin
              state <= ST_ARB;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: expected bytes queued at stimulus time, checked at accept and tx_start.
module tb_uart_tx_arbiter;

  localparam int ACK = 8;
  localparam int GAP = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_last = '0;
  logic [1:0]  req_ready;
  logic [1:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tsr_busy;
  logic        timeout_err;
  logic        err_clr = 1'b0;

  logic        tsr_auto = 1'b1;
  logic        busy_auto = 1'b0;
  logic        busy_man = 1'b0;
  assign tsr_busy = tsr_auto ? busy_auto : busy_man;

  uart_tx_arbiter #(
    .DATA_WIDTH  (8),
    .NUM_REQ     (2),
    .ACK_TIMEOUT (ACK),
    .GAP_CYCLES  (GAP)
  ) dut (
    .CLK         (clk),
    .RST         (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .grant       (grant),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tsr_busy    (tsr_busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         owner;
    logic [7:0] data;
    bit         cont;
  } exp_t;

  exp_t       sb[$];
  logic [8:0] src0[$];
  logic [8:0] src1[$];

  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;
  int   fall_cyc = 0;
  int   n_start = 0;
  int   bleft = 0;
  logic [1:0] acc_s = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh(input int o);
    return (o == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic push_exp(input int o, input logic [7:0] d, input bit c);
    exp_t e;
    e.owner = o;
    e.data  = d;
    e.cont  = c;
    sb.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Requester drivers: advance a stream after its byte was accepted at this edge.
  always @(posedge clk) begin
    #1;
    if (acc_s[0] && src0.size() > 0) void'(src0.pop_front());
    if (acc_s[1] && src1.size() > 0) void'(src1.pop_front());
    req_valid[0]    = (src0.size() > 0);
    req_data[7:0]   = (src0.size() > 0) ? src0[0][7:0] : 8'h00;
    req_last[0]     = (src0.size() > 0) ? src0[0][8] : 1'b0;
    req_valid[1]    = (src1.size() > 0);
    req_data[15:8]  = (src1.size() > 0) ? src1[0][7:0] : 8'h00;
    req_last[1]     = (src1.size() > 0) ? src1[0][8] : 1'b0;
  end

  // Monitor + transmitter model (busy for 4 cycles starting with the tx_start cycle).
  always @(negedge clk) begin
    exp_t e;
    acc_s = req_valid & req_ready;
    if (|req_ready) begin
      if (sb.size() == 0) begin
        chk("ready_unexp", {30'd0, req_ready}, 32'd0);
      end else begin
        chk("ready_owner", {30'd0, req_ready}, {30'd0, oh(sb[0].owner)});
        chk("ready_busy", {31'd0, tsr_busy}, 32'd0);
        if (sb[0].cont) chk("gap_cycles", cyc - fall_cyc, GAP + 1);
      end
    end
    if (tx_start) begin
      n_start++;
      if (sb.size() == 0) begin
        chk("start_unexp", {31'd0, tx_start}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("tx_data", {24'd0, tx_data}, {24'd0, e.data});
        chk("tx_grant", {30'd0, grant}, {30'd0, oh(e.owner)});
      end
      bleft = 4;
    end
    if (bleft > 0) begin
      busy_auto = 1'b1;
      bleft--;
    end else begin
      if (busy_auto) fall_cyc = cyc;
      busy_auto = 1'b0;
    end
  end

  task automatic wait_drain();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && src0.size() == 0 && src1.size() == 0 && grant == 2'b00 && !tsr_busy)
        break;
    end
    chk("drain_left", sb.size(), 0);
    chk("drain_grant", {30'd0, grant}, 32'd0);
  endtask

  task automatic wait_start();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (tx_start) break;
    end
    chk("start_seen", {31'd0, tx_start}, 32'd1);
  endtask

  initial begin
    int saved;
    repeat (3) @(negedge clk);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_start", {31'd0, tx_start}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_err", {31'd0, timeout_err}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single requester, three-byte message.
    push_exp(0, 8'h41, 0); push_exp(0, 8'h54, 1); push_exp(0, 8'h0D, 1);
    src0.push_back({1'b0, 8'h41}); src0.push_back({1'b0, 8'h54}); src0.push_back({1'b1, 8'h0D});
    wait_drain();

    // Contention with pointer at 1: requester 1 first, then requester 0's message.
    push_exp(1, 8'h60, 0); push_exp(0, 8'h30, 0); push_exp(0, 8'h31, 1);
    src0.push_back({1'b0, 8'h30}); src0.push_back({1'b1, 8'h31});
    src1.push_back({1'b1, 8'h60});
    wait_drain();

    // Next contention: pointer back at 1, requester 1 message locks out requester 0.
    push_exp(1, 8'h80, 0); push_exp(1, 8'h81, 1); push_exp(0, 8'h70, 0);
    src0.push_back({1'b1, 8'h70});
    src1.push_back({1'b0, 8'h80}); src1.push_back({1'b1, 8'h81});
    wait_drain();

    // Acknowledge timeout, then clear.
    tsr_auto = 1'b0;
    busy_man = 1'b0;
    push_exp(0, 8'h55, 0);
    src0.push_back({1'b1, 8'h55});
    wait_start();
    repeat (8) @(negedge clk);
    chk("to_early", {31'd0, timeout_err}, 32'd0);
    @(negedge clk);
    chk("to_set", {31'd0, timeout_err}, 32'd1);
    chk("to_grant", {30'd0, grant}, 32'd0);
    repeat (3) @(negedge clk);
    chk("to_sticky", {31'd0, timeout_err}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("to_clr", {31'd0, timeout_err}, 32'd0);

    // Timeout coinciding with err_clr: set wins.
    err_clr = 1'b1;
    push_exp(0, 8'h56, 0);
    src0.push_back({1'b1, 8'h56});
    wait_start();
    repeat (8) @(negedge clk);
    chk("tw_early", {31'd0, timeout_err}, 32'd0);
    @(negedge clk);
    chk("tw_set", {31'd0, timeout_err}, 32'd1);
    @(negedge clk);
    chk("tw_clr", {31'd0, timeout_err}, 32'd0);
    err_clr = 1'b0;

    // Reset during WAIT_DONE, then held off by a busy shift register.
    push_exp(1, 8'h99, 0);
    src1.push_back({1'b1, 8'h99});
    wait_start();
    busy_man = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_grant", {30'd0, grant}, 32'd0);
    chk("ar_start", {31'd0, tx_start}, 32'd0);
    chk("ar_data", {24'd0, tx_data}, 32'd0);
    chk("ar_ready", {30'd0, req_ready}, 32'd0);
    chk("ar_err", {31'd0, timeout_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saved = n_start;
    src0.push_back({1'b0, 8'hA0}); src0.push_back({1'b1, 8'hA1});
    src1.push_back({1'b1, 8'hB0});
    repeat (10) @(negedge clk);
    chk("busy_hold_starts", n_start, saved);
    chk("busy_hold_grant", {30'd0, grant}, 32'd0);
    push_exp(0, 8'hA0, 0); push_exp(0, 8'hA1, 1); push_exp(1, 8'hB0, 0);
    tsr_auto = 1'b1;
    busy_man = 1'b0;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit path (transmitter timing control + shift register) between NUM_REQ byte-stream requesters, e.g. the AT-command generator and the debug/echo source for the ESP8266 link.
- Round-robin arbitration at message granularity: the grant is held until the requester's last byte of a message is sent.
- Per byte, the block presents tx_data, pulses tx_start, then tracks tsr_busy through acknowledge and completion.
- Sits between the requesters and the TX datapath, in the same clock domain as BCLK.

Parameters:
- DATA_WIDTH, 8: bits per character.
- NUM_REQ, 2: number of requesters, 2..4.
- ACK_TIMEOUT, 64: maximum cycles from the tx_start pulse to tsr_busy rising before the byte is aborted.
- GAP_CYCLES, 0: idle cycles inserted after each byte completes, 0..255.

Ports:
- CLK  in  1  clock (the BCLK domain of the TX path).
- RST  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  requester i has a byte available.
- req_data  in  NUM_REQ*DATA_WIDTH  byte of requester i, in slice i.
- req_last  in  NUM_REQ  the byte of requester i ends its message.
- req_ready  out  NUM_REQ  one-hot, one-cycle acceptance of requester i's byte.
- grant  out  NUM_REQ  one-hot current owner; zero when unowned.
- tx_data  out  DATA_WIDTH  byte driven to the shift register load input.
- tx_start  out  1  one-cycle start pulse to the transmitter timing control.
- tsr_busy  in  1  transmitter busy.
- timeout_err  out  1  sticky: an acknowledge timeout occurred.
- err_clr  in  1  clears timeout_err.

Behaviour:
- Reset (RST=0, asynchronous): all outputs 0, state IDLE, round-robin pointer 0, counters 0.
- States: IDLE, ARB, LOAD, WAIT_ACK, WAIT_DONE, GAP.
- IDLE: if tsr_busy=0 and any req_valid is high, go to ARB. If tsr_busy=1 (foreign or leftover frame), stay in IDLE.
- ARB:
  - When unowned, pick the first valid requester searching from the pointer upward with wrap-around, and set grant.
  - When owned, wait for req_valid of the owner only; other requesters are ignored.
  - On the owner's req_valid: latch req_data into tx_data, latch req_last, assert req_ready[owner] for exactly that cycle, go to LOAD.
- LOAD: tx_start=1 for one cycle, clear the timeout counter, go to WAIT_ACK.
- WAIT_ACK:
  - tsr_busy=1 goes to WAIT_DONE.
  - If the counter reaches ACK_TIMEOUT-1 without busy: set timeout_err, drop the byte, release the grant, advance the pointer, go to IDLE.
- WAIT_DONE: on tsr_busy=0, go to GAP if GAP_CYCLES>0, else go to the release step.
- GAP: count GAP_CYCLES cycles, then go to the release step.
- Release step:
  - If the latched last=1: clear grant, pointer = owner+1 mod NUM_REQ, go to IDLE.
  - Otherwise go to ARB keeping the grant.
- Latency, best case: req_valid high in ARB → req_ready in the same cycle → tx_start the next cycle.
- tx_data is held stable from LOAD until the next byte is accepted.
- Simultaneous requests in ARB while unowned: the pointer decides. Example: pointer=1 with req_valid=2'b11 grants 1.
- Owner drops req_valid mid-message: the grant is held indefinitely. No timeout applies in ARB.
- err_clr and a new timeout in the same cycle: set wins.
- timeout_err changes only on a timeout or err_clr.
- RST asserted mid-frame: the state returns to IDLE. The frame already in the shift register is not aborted by this block.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum, with explicit 3-bit encoding;
  - DATA_WIDTH_DEF=8;
  - the tx_start pulse width constant (1).
- One sub-module, rr_arbiter: a NUM_REQ round-robin picker taking req and pointer and returning a one-hot grant. It is purely combinational and instantiated once.

Test Plan:
- Single requester: req0 sends 3 bytes 0x41,0x54,0x0D with last on 0x0D. Expect 3 tx_start pulses, tx_data in order, each next byte only after tsr_busy falls; grant returns to 0; pointer=1.
- Contention: both valid from reset. Expect req0's full message (2 bytes) first, then req1's message, then req0 again on the next contention.
- Message lock: req1 asserts valid during req0's multi-byte message. Expect req_ready[1]=0 until req0's last byte completes.
- Ack timeout: tsr_busy held 0 after tx_start with ACK_TIMEOUT=8. Expect timeout_err=1 exactly 8 cycles after the tx_start pulse and grant cleared; err_clr then clears it.
- GAP_CYCLES=5: expect exactly 5 idle cycles between tsr_busy falling and the next req_ready.
- Reset asserted during WAIT_DONE: all outputs 0 asynchronously; after release with tsr_busy=1, stays in IDLE until tsr_busy=0.
